// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for the data-RAM port arbiter: FSM states,
// requester indices, operation decode and round-robin step.
package ram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NULL = 2'd0,
    OP_WR   = 2'd1,
    OP_RD   = 2'd2
  } op_t;

  localparam logic [1:0] REQ_I   = 2'd0;
  localparam logic [1:0] REQ_S   = 2'd1;
  localparam logic [1:0] REQ_A   = 2'd2;
  localparam int         NUM_REQ = 3;

  // WR wins when both strobes are set.
  function automatic op_t decode_op(
    input logic rd,
    input logic wr
  );
    if (wr) return OP_WR;
    if (rd) return OP_RD;
    return OP_NULL;
  endfunction

  function automatic logic [1:0] rr_next(
    input logic [1:0] idx
  );
    return (idx >= REQ_A) ? REQ_I : idx + 2'd1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker.
// Ports: req (eligible vector), last (previous owner) -> grant, valid.
module rr_pick3
  import ram_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  output logic [1:0]         grant,
  output logic               valid
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  always_comb begin
    c0    = rr_next(last);
    c1    = rr_next(c0);
    c2    = rr_next(c1);
    valid = |req;
    grant = c0;
    if (req[c0])      grant = c0;
    else if (req[c1]) grant = c1;
    else if (req[c2]) grant = c2;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among I/S/A requesters.
// Ports: iCLK, iRST (sync, active-low); per-requester iCE/iRD/iWR/iADDR/
// iWDATA in, oRDATA/oACK out; RAM side oRAM_CE/RD/WR/ADDR/WDATA, iRAM_RDATA;
// status oBUSY, oOWNER. Define AMO_LOCK_EN to hold A's read-modify-write
// atomic against the other requesters.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iCE_I,
  input  logic              iCE_S,
  input  logic              iCE_A,
  input  logic              iRD_I,
  input  logic              iRD_S,
  input  logic              iRD_A,
  input  logic              iWR_I,
  input  logic              iWR_S,
  input  logic              iWR_A,
  input  logic [ADDR_W-1:0] iADDR_I,
  input  logic [ADDR_W-1:0] iADDR_S,
  input  logic [ADDR_W-1:0] iADDR_A,
  input  logic [DATA_W-1:0] iWDATA_I,
  input  logic [DATA_W-1:0] iWDATA_S,
  input  logic [DATA_W-1:0] iWDATA_A,
  output logic [DATA_W-1:0] oRDATA_I,
  output logic [DATA_W-1:0] oRDATA_S,
  output logic [DATA_W-1:0] oRDATA_A,
  output logic              oACK_I,
  output logic              oACK_S,
  output logic              oACK_A,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic [DATA_W-1:0] oRAM_WDATA,
  input  logic [DATA_W-1:0] iRAM_RDATA,
  output logic              oBUSY,
  output logic [1:0]        oOWNER
);

  localparam int             CNT_W    = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  state_t              state;
  state_t              state_nx;
  op_t                 op;
  op_t                 sel_op;
  logic [1:0]          owner;
  logic [1:0]          ptr;
  logic [1:0]          pick;
  logic                pick_vld;
  logic                sel_rd;
  logic                sel_wr;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt;
  logic                ack_q;
  logic [NUM_REQ-1:0]  ce_v;
  logic [NUM_REQ-1:0]  mask;
  logic [NUM_REQ-1:0]  elig;
  logic                in_grant;

  assign ce_v = {iCE_A, iCE_S, iCE_I};
  // Whoever was acked last cycle sits out one IDLE cycle.
  assign mask = ack_q ? (NUM_REQ'(1) << owner) : '0;

`ifdef AMO_LOCK_EN
  logic lock;
  assign elig = lock ? {iCE_A, 2'b00} : (ce_v & ~mask);
`else
  assign elig = ce_v & ~mask;
`endif

  rr_pick3 u_pick (
    .req   (elig),
    .last  (ptr),
    .grant (pick),
    .valid (pick_vld)
  );

  always_comb begin
    sel_rd    = iRD_I;
    sel_wr    = iWR_I;
    sel_addr  = iADDR_I;
    sel_wdata = iWDATA_I;
    unique case (pick)
      REQ_S: begin
        sel_rd    = iRD_S;
        sel_wr    = iWR_S;
        sel_addr  = iADDR_S;
        sel_wdata = iWDATA_S;
      end
      REQ_A: begin
        sel_rd    = iRD_A;
        sel_wr    = iWR_A;
        sel_addr  = iADDR_A;
        sel_wdata = iWDATA_A;
      end
      default: ;
    endcase
    sel_op = decode_op(sel_rd, sel_wr);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (pick_vld)
          state_nx = (sel_op == OP_NULL) ? ST_ACK : ST_GRANT;
      ST_GRANT:
        state_nx = (op == OP_WR) ? ST_ACK : ST_WAIT;
      ST_WAIT:
        if (cnt == '0) state_nx = ST_ACK;
      ST_ACK:
        state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state    <= ST_IDLE;
      op       <= OP_NULL;
      owner    <= REQ_I;
      ptr      <= REQ_A;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      ack_q    <= 1'b0;
      oRDATA_I <= '0;
      oRDATA_S <= '0;
      oRDATA_A <= '0;
`ifdef AMO_LOCK_EN
      lock     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      ack_q <= (state == ST_ACK);
      if (state == ST_IDLE && pick_vld) begin
        owner   <= pick;
        ptr     <= pick;
        op      <= sel_op;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (state == ST_GRANT)
        cnt <= CNT_LOAD;
      else if (state == ST_WAIT)
        cnt <= cnt - 1'b1;
      if (state == ST_WAIT && cnt == '0) begin
        unique case (owner)
          REQ_I:   oRDATA_I <= iRAM_RDATA;
          REQ_S:   oRDATA_S <= iRAM_RDATA;
          REQ_A:   oRDATA_A <= iRAM_RDATA;
          default: ;
        endcase
      end
`ifdef AMO_LOCK_EN
      if (state == ST_ACK && owner == REQ_A) begin
        if (op == OP_RD)      lock <= 1'b1;
        else if (op == OP_WR) lock <= 1'b0;
      end else if (state == ST_IDLE && lock && !iCE_A) begin
        lock <= 1'b0;
      end
`endif
    end
  end

  assign in_grant   = (state == ST_GRANT);
  assign oRAM_CE    = in_grant;
  assign oRAM_WR    = in_grant && (op == OP_WR);
  assign oRAM_RD    = in_grant && (op == OP_RD);
  assign oRAM_ADDR  = in_grant ? addr_q : '0;
  assign oRAM_WDATA = in_grant ? wdata_q : '0;
  assign oACK_I     = (state == ST_ACK) && (owner == REQ_I);
  assign oACK_S     = (state == ST_ACK) && (owner == REQ_S);
  assign oACK_A     = (state == ST_ACK) && (owner == REQ_A);
  assign oBUSY      = (state != ST_IDLE);
  assign oOWNER     = owner;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus
// randomized traffic against a transaction-schedule reference model.
module tb_ram_port_arbiter;

  localparam int L = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       ce;
  logic [2:0]       rd;
  logic [2:0]       wr;
  logic [2:0][7:0]  addr;
  logic [2:0][31:0] wdata;
  logic [31:0]      ram_rdata;
  wire  [2:0][31:0] rdata;
  wire  [2:0]       ack;
  wire              ram_ce;
  wire              ram_rd;
  wire              ram_wr;
  wire  [7:0]       ram_addr;
  wire  [31:0]      ram_wdata;
  wire              busy;
  wire  [1:0]       owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .RD_LATENCY (L),
    .ADDR_W     (8),
    .DATA_W     (32)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst),
    .iCE_I      (ce[0]),
    .iCE_S      (ce[1]),
    .iCE_A      (ce[2]),
    .iRD_I      (rd[0]),
    .iRD_S      (rd[1]),
    .iRD_A      (rd[2]),
    .iWR_I      (wr[0]),
    .iWR_S      (wr[1]),
    .iWR_A      (wr[2]),
    .iADDR_I    (addr[0]),
    .iADDR_S    (addr[1]),
    .iADDR_A    (addr[2]),
    .iWDATA_I   (wdata[0]),
    .iWDATA_S   (wdata[1]),
    .iWDATA_A   (wdata[2]),
    .oRDATA_I   (rdata[0]),
    .oRDATA_S   (rdata[1]),
    .oRDATA_A   (rdata[2]),
    .oACK_I     (ack[0]),
    .oACK_S     (ack[1]),
    .oACK_A     (ack[2]),
    .oRAM_CE    (ram_ce),
    .oRAM_RD    (ram_rd),
    .oRAM_WR    (ram_wr),
    .oRAM_ADDR  (ram_addr),
    .oRAM_WDATA (ram_wdata),
    .iRAM_RDATA (ram_rdata),
    .oBUSY      (busy),
    .oOWNER     (owner)
  );

  task automatic clear_in();
    ce        = '0;
    rd        = '0;
    wr        = '0;
    addr      = '0;
    wdata     = '0;
    ram_rdata = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_in();
    nxt();
    nxt();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ce  = 3'b111;
    wr  = 3'b111;
    nxt();
    @(negedge clk);
    checks++;
    if ({ram_ce, ram_rd, ram_wr, ack, busy, owner} !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0",
               {ram_ce, ram_rd, ram_wr, ack, busy, owner});
    end
    checks++;
    if ({ram_addr, ram_wdata, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h want 0",
               {ram_addr, ram_wdata, rdata});
    end
    nxt();
  endtask

  task automatic test_store_write();
    do_reset();
    ce[1]    = 1'b1;
    wr[1]    = 1'b1;
    addr[1]  = 8'h10;
    wdata[1] = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({busy, ram_ce} !== 2'b00) begin
      errors++;
      $display("FAIL st_c0 got %b want 00", {busy, ram_ce});
    end
    nxt();
    clear_in();
    @(negedge clk);
    checks++;
    if ({ram_ce, ram_rd, ram_wr} !== 3'b101) begin
      errors++;
      $display("FAIL st_strobe got %b want 101", {ram_ce, ram_rd, ram_wr});
    end
    checks++;
    if ({ram_addr, ram_wdata} !== {8'h10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL st_bus got %h/%h want 10/deadbeef", ram_addr, ram_wdata);
    end
    checks++;
    if ({ack, owner} !== {3'b000, 2'd1}) begin
      errors++;
      $display("FAIL st_c1 ack/owner got %b/%0d want 000/1", ack, owner);
    end
    nxt();
    @(negedge clk);
    checks++;
    if ({ack, ram_ce} !== 4'b0100) begin
      errors++;
      $display("FAIL st_ack got %b want 0100", {ack, ram_ce});
    end
    nxt();
    @(negedge clk);
    checks++;
    if ({ack, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL st_c3 got %b want 0000", {ack, busy});
    end
  endtask

  task automatic test_load_read();
    do_reset();
    ce[0]   = 1'b1;
    rd[0]   = 1'b1;
    addr[0] = 8'h04;
    for (int c = 0; c < L + 6; c++) begin
      ram_rdata = (c == 1 + L) ? 32'h12345678 : (32'hBAD00000 | 32'(c));
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if ({ram_ce, ram_rd, ram_wr, ram_addr} !== {3'b110, 8'h04}) begin
          errors++;
          $display("FAIL ld_grant got %b/%h want 110/04",
                   {ram_ce, ram_rd, ram_wr}, ram_addr);
        end
      end else if (c >= 2 && c <= 1 + L) begin
        checks++;
        if ({ram_ce, ram_rd, ram_wr, busy, ack} !== 7'b0001000) begin
          errors++;
          $display("FAIL ld_wait c=%0d got %b want 0001000",
                   c, {ram_ce, ram_rd, ram_wr, busy, ack});
        end
      end else if (c == 2 + L) begin
        checks++;
        if ({ack, rdata[0]} !== {3'b001, 32'h12345678}) begin
          errors++;
          $display("FAIL ld_ack got %b/%h want 001/12345678", ack, rdata[0]);
        end
      end else if (c > 2 + L) begin
        checks++;
        if ({ack, rdata[0]} !== {3'b000, 32'h12345678}) begin
          errors++;
          $display("FAIL ld_hold c=%0d got %b/%h want 000/12345678",
                   c, ack, rdata[0]);
        end
      end
      nxt();
      if (c == 0) begin
        ce = '0;
        rd = '0;
      end
    end
  endtask

  task automatic test_fairness();
    logic [2:0] exp;
    int         prev;
    do_reset();
    ce    = 3'b111;
    wr    = 3'b111;
    addr  = {8'h3A, 8'h2A, 8'h1A};
    prev  = -1;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      exp = (c % 3 == 2) ? 3'(1 << ((c / 3) % 3)) : 3'b000;
      checks++;
      if (ack !== exp) begin
        errors++;
        $display("FAIL fair_ack c=%0d got %b want %b", c, ack, exp);
      end
      if (ram_ce) begin
        checks++;
        if (int'(owner) == prev) begin
          errors++;
          $display("FAIL fair_repeat c=%0d got owner %0d want not %0d",
                   c, owner, prev);
        end
        prev = int'(owner);
      end
      nxt();
    end
    clear_in();
  endtask

  task automatic test_rdwr_both();
    do_reset();
    ce[0]    = 1'b1;
    rd[0]    = 1'b1;
    wr[0]    = 1'b1;
    addr[0]  = 8'h33;
    wdata[0] = 32'hA5A5_0F0F;
    @(negedge clk);
    nxt();
    clear_in();
    @(negedge clk);
    checks++;
    if ({ram_ce, ram_rd, ram_wr, ram_wdata} !== {3'b101, 32'hA5A5_0F0F}) begin
      errors++;
      $display("FAIL rdwr_strobe got %b/%h want 101/a5a50f0f",
               {ram_ce, ram_rd, ram_wr}, ram_wdata);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (ack !== 3'b001) begin
      errors++;
      $display("FAIL rdwr_ack got %b want 001", ack);
    end
  endtask

  task automatic test_null_access();
    do_reset();
    ce[2] = 1'b1;
    @(negedge clk);
    nxt();
    clear_in();
    @(negedge clk);
    checks++;
    if ({ack, ram_ce, busy} !== 5'b10001) begin
      errors++;
      $display("FAIL null_ack got %b want 10001", {ack, ram_ce, busy});
    end
    nxt();
    @(negedge clk);
    checks++;
    if ({ack, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL null_done got %b want 0000", {ack, busy});
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    ce[0]     = 1'b1;
    rd[0]     = 1'b1;
    addr[0]   = 8'h08;
    ram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    nxt();
    ce = '0;
    rd = '0;
    @(negedge clk);
    nxt();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait busy got %b want 1", busy);
    end
    rst = 1'b0;
    nxt();
    ce       = 3'b011;
    wr       = 3'b011;
    addr[0]  = 8'hA0;
    addr[1]  = 8'hB0;
    @(negedge clk);
    checks++;
    if ({ram_ce, ram_rd, ram_wr, ack, busy, owner, ram_addr, rdata} !== '0) begin
      errors++;
      $display("FAIL mid_rst got %b/%h/%h want 0",
               {ram_ce, ram_rd, ram_wr, ack, busy, owner}, ram_addr, rdata);
    end
    nxt();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ack !== 3'b000) begin
      errors++;
      $display("FAIL mid_noack got %b want 000", ack);
    end
    nxt();
    clear_in();
    @(negedge clk);
    checks++;
    if ({ram_ce, ram_wr, ram_addr} !== {2'b11, 8'hA0}) begin
      errors++;
      $display("FAIL mid_first got %b/%h want 11/a0",
               {ram_ce, ram_wr}, ram_addr);
    end
    nxt();
    @(negedge clk);
    checks++;
    if (ack !== 3'b001) begin
      errors++;
      $display("FAIL mid_ack got %b want 001", ack);
    end
  endtask

  task automatic test_amo_lock();
    int rd_ack;
    int a_wr_ack;
    int s_ack;
    int exp_a;
    int exp_s;
    do_reset();
    ce[2]   = 1'b1;
    rd[2]   = 1'b1;
    addr[2] = 8'h20;
    rd_ack   = -1;
    a_wr_ack = -1;
    s_ack    = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ack[2] && rd_ack < 0) rd_ack = c;
      else if (ack[2] && a_wr_ack < 0) a_wr_ack = c;
      if (ack[1] && s_ack < 0) s_ack = c;
      nxt();
      if (c == 0) begin
        ce[1]    = 1'b1;
        wr[1]    = 1'b1;
        addr[1]  = 8'h44;
        wdata[1] = 32'h5555_AAAA;
      end
      if (rd_ack == c) begin
        rd[2]    = 1'b0;
        wr[2]    = 1'b1;
        wdata[2] = 32'h0000_0001;
      end
      if (a_wr_ack == c) ce[2] = 1'b0;
      if (s_ack == c) ce[1] = 1'b0;
    end
    clear_in();
`ifdef AMO_LOCK_EN
    exp_a = 5 + L;
    exp_s = 8 + L;
`else
    exp_s = 5 + L;
    exp_a = 8 + L;
`endif
    checks++;
    if (rd_ack != 2 + L) begin
      errors++;
      $display("FAIL amo_rd_ack got %0d want %0d", rd_ack, 2 + L);
    end
    checks++;
    if (a_wr_ack != exp_a) begin
      errors++;
      $display("FAIL amo_a_wr got %0d want %0d", a_wr_ack, exp_a);
    end
    checks++;
    if (s_ack != exp_s) begin
      errors++;
      $display("FAIL amo_s_wr got %0d want %0d", s_ack, exp_s);
    end
  endtask

  // Model: each IDLE decision schedules the whole transaction
  // (grant cycle, ack cycle, capture) with plain arithmetic.
  task automatic test_random();
    int               next_idle;
    int               last;
    int               last_ack;
    int               cur;
    int               kind;
    int               gcyc;
    int               acyc;
    int               k;
    bit               found;
    logic [7:0]       caddr;
    logic [31:0]      cwd;
    logic [2:0][31:0] mrd;
    logic [1:0]       mown;
    logic [2:0]       el;
    logic [2:0]       eack;
    logic [2:0]       estr;
    logic [7:0]       eaddr;
    logic [31:0]      ewd;
    logic             ebusy;
`ifdef AMO_LOCK_EN
    bit               lock;
    lock = 1'b0;
`endif
    do_reset();
    next_idle = 0;
    last      = 2;
    last_ack  = -10;
    cur       = 0;
    kind      = 0;
    gcyc      = -1;
    acyc      = -1;
    caddr     = '0;
    cwd       = '0;
    mrd       = '0;
    mown      = 2'd0;
    for (int t = 0; t < 600; t++) begin
      ce = 3'($urandom);
      rd = 3'($urandom);
      wr = 3'($urandom);
      for (int r = 0; r < 3; r++) begin
        addr[r]  = 8'($urandom);
        wdata[r] = $urandom;
      end
      ram_rdata = $urandom;
      @(negedge clk);
      estr  = (t == gcyc) ? {1'b1, kind == 2, kind == 1} : 3'b000;
      eaddr = (t == gcyc) ? caddr : 8'h00;
      ewd   = (t == gcyc) ? cwd : 32'h0;
      eack  = (t == acyc) ? 3'(1 << cur) : 3'b000;
      ebusy = (t < next_idle);
      checks++;
      if ({ram_ce, ram_rd, ram_wr} !== estr) begin
        errors++;
        $display("FAIL rnd_strobe t=%0d got %b want %b",
                 t, {ram_ce, ram_rd, ram_wr}, estr);
      end
      checks++;
      if ({ram_addr, ram_wdata} !== {eaddr, ewd}) begin
        errors++;
        $display("FAIL rnd_bus t=%0d got %h/%h want %h/%h",
                 t, ram_addr, ram_wdata, eaddr, ewd);
      end
      checks++;
      if ({ack, busy, owner} !== {eack, ebusy, mown}) begin
        errors++;
        $display("FAIL rnd_ctl t=%0d got %b/%b/%0d want %b/%b/%0d",
                 t, ack, busy, owner, eack, ebusy, mown);
      end
      checks++;
      if (rdata !== mrd) begin
        errors++;
        $display("FAIL rnd_rdata t=%0d got %h want %h", t, rdata, mrd);
      end
      if (kind == 2 && t == acyc - 1) mrd[cur] = ram_rdata;
      if (t == acyc) begin
        last_ack = t;
`ifdef AMO_LOCK_EN
        if (cur == 2 && kind == 2) lock = 1'b1;
        else if (cur == 2 && kind == 1) lock = 1'b0;
`endif
      end
      if (t == next_idle) begin
        el = ce & ~((last_ack == t - 1) ? 3'(1 << last) : 3'b000);
`ifdef AMO_LOCK_EN
        if (lock) begin
          el = {ce[2], 2'b00};
          if (!ce[2]) lock = 1'b0;
        end
`endif
        found = 1'b0;
        for (int o = 1; o <= 3; o++) begin
          k = (last + o) % 3;
          if (!found && el[k]) begin
            found = 1'b1;
            cur   = k;
          end
        end
        if (found) begin
          last  = cur;
          mown  = 2'(cur);
          kind  = wr[cur] ? 1 : (rd[cur] ? 2 : 0);
          caddr = addr[cur];
          cwd   = wdata[cur];
          gcyc  = (kind == 0) ? -1 : t + 1;
          acyc  = (kind == 0) ? t + 1 : ((kind == 1) ? t + 2 : t + 2 + L);
          next_idle = acyc + 1;
        end else begin
          next_idle = t + 1;
        end
      end
      nxt();
    end
    clear_in();
  endtask

  initial begin
    clear_in();
    test_reset();
    test_store_write();
    test_load_read();
    test_fairness();
    test_rdwr_both();
    test_null_access();
    test_reset_mid_read();
    test_amo_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
